// File: rtl/key_step_debounce.sv
// Push-button debouncer: two-flop synchronizer and a five-state FSM with one shared timer.
// Each accepted press gives a one-cycle step pulse, with optional auto-repeat while the button is held.
`timescale 1ns/1ps
module key_step_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter int CNT_W           = 26
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic iKey,
  input  logic iRepeatEn,
  output logic oPulse,
  output logic oLevel
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PRESS_CHK   = 3'd1,
    HELD        = 3'd2,
    REPEAT      = 3'd3,
    RELEASE_CHK = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             key_m_q, key_s_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             level_q, level_d;

  // synchronizer stage; both flops idle at "released"
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      key_m_q <= 1'b1;
      key_s_q <= 1'b1;
    end else begin
      key_m_q <= iKey;
      key_s_q <= key_m_q;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end

  // key_s is tested before any terminal count, so a leaving key never fires a pulse
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!key_s_q) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (key_s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (key_s_q) begin
          state_d = RELEASE_CHK;
          cnt_d   = '0;
        end else if (iRepeatEn && (cnt_q == RD_LAST)) begin
          state_d = REPEAT;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else if (iRepeatEn) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      REPEAT: begin
        if (key_s_q) begin
          state_d = RELEASE_CHK;
          cnt_d   = '0;
        end else if (!iRepeatEn) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == RP_LAST) begin
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RELEASE_CHK: begin
        if (!key_s_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == HELD) || (state_d == REPEAT) || (state_d == RELEASE_CHK);
  end

  assign oPulse = pulse_q;
  assign oLevel = level_q;

endmodule
